// File: rtl/cga_pixel_fetch_if.sv
// rtl/cga_pixel_fetch_if.sv - CRTC/VRAM/serializer signal bundle for the CGA pixel fetch stage
interface cga_pixel_fetch_if;
  logic        char_clk;
  logic        display_enable;
  logic        graphics_mode;
  logic [13:0] crtc_addr;
  logic [4:0]  row_addr;
  logic [18:0] pixel_addr;
  logic        pixel_read;
  logic [7:0]  pixel_data;
  logic        vram_busy;
  logic [7:0]  byte0;
  logic [7:0]  byte1;
  logic        fetch_valid;
  logic        blank;
  logic        overrun;

  // Environment side: CRTC timing, VRAM arbiter and downstream serializer
  modport master (
    output char_clk, display_enable, graphics_mode, crtc_addr, row_addr,
    output pixel_data, vram_busy,
    input  pixel_addr, pixel_read, byte0, byte1, fetch_valid, blank, overrun
  );

  // Fetch block side
  modport slave (
    input  char_clk, display_enable, graphics_mode, crtc_addr, row_addr,
    input  pixel_data, vram_busy,
    output pixel_addr, pixel_read, byte0, byte1, fetch_valid, blank, overrun
  );
endinterface

// File: rtl/cga_pixel_fetch.sv
// rtl/cga_pixel_fetch.sv - per-slot two-byte VRAM fetch for CGA text/graphics; CGA_SNOW_EN passes collided reads through as snow
module cga_pixel_fetch #(
  parameter logic [18:0] BASE_ADDR = 19'h18000,
  parameter int          MIN_SLOT  = 6
) (
  input logic             clk,
  input logic             reset_l,
  cga_pixel_fetch_if.slave bus
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_A0   = 3'd1;
  localparam logic [2:0] ST_A1   = 3'd2;
  localparam logic [2:0] ST_CAP  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;
  localparam logic [2:0] ST_BLK  = 3'd5;

  // A full fetch occupies five cycles; shorter slots could never complete
  if (MIN_SLOT < 5) begin : g_slot_shorter_than_fetch
  end

  logic [2:0]  r_state;
  logic [12:0] r_ma;
  logic        r_ra0;
  logic        r_gfx;
  logic [7:0]  r_hold0;
  logic [7:0]  r_byte0;
  logic [7:0]  r_byte1;
  logic        r_blank;
  logic        r_fetch_valid;
  logic        r_overrun;
  logic [7:0]  w_byte0;
  logic [7:0]  w_byte1;
  logic        w_b;
  logic        w_pixel_read;
  logic [18:0] w_pixel_addr;

  // Slot sequencer; output bytes/strobes are loaded on leaving CAP or BLK so they line up with DONE
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state       <= ST_IDLE;
      r_ma          <= '0;
      r_ra0         <= 1'b0;
      r_gfx         <= 1'b0;
      r_hold0       <= '0;
      r_byte0       <= '0;
      r_byte1       <= '0;
      r_blank       <= 1'b0;
      r_fetch_valid <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_fetch_valid <= 1'b0;
      if (bus.char_clk && (r_state != ST_IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (bus.char_clk) begin
            r_ma    <= bus.crtc_addr[12:0];
            r_ra0   <= bus.row_addr[0];
            r_gfx   <= bus.graphics_mode;
            r_state <= bus.display_enable ? ST_A0 : ST_BLK;
          end
        end
        ST_A0: r_state <= ST_A1;
        ST_A1: begin
          r_hold0 <= bus.pixel_data;
          r_state <= ST_CAP;
        end
        ST_CAP: begin
          r_byte0       <= w_byte0;
          r_byte1       <= w_byte1;
          r_blank       <= 1'b0;
          r_fetch_valid <= 1'b1;
          r_state       <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        ST_BLK: begin
          r_byte0       <= '0;
          r_byte1       <= '0;
          r_blank       <= 1'b1;
          r_fetch_valid <= 1'b1;
          r_state       <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef CGA_SNOW_EN
  // Collided reads arrive as 8'hFF and are shown as-is
  assign w_byte0 = r_hold0;
  assign w_byte1 = bus.pixel_data;
`else
  logic       r_busy0;
  logic       r_busy1;
  logic [7:0] r_shadow0;
  logic [7:0] r_shadow1;

  // Track which byte read was pre-empted and keep the last clean copy of each byte
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_busy0   <= 1'b0;
      r_busy1   <= 1'b0;
      r_shadow0 <= '0;
      r_shadow1 <= '0;
    end else begin
      if (r_state == ST_A0) begin
        r_busy0 <= bus.vram_busy;
      end
      if (r_state == ST_A1) begin
        r_busy1 <= bus.vram_busy;
      end
      if (r_state == ST_CAP) begin
        if (!r_busy0) begin
          r_shadow0 <= r_hold0;
        end
        if (!r_busy1) begin
          r_shadow1 <= bus.pixel_data;
        end
      end
    end
  end

  assign w_byte0 = r_busy0 ? r_shadow0 : r_hold0;
  assign w_byte1 = r_busy1 ? r_shadow1 : bus.pixel_data;
`endif

  // Address the current byte of the latched slot; MA bit 13 (text) and 13:12 (graphics) wrap inside the window
  always_comb begin
    w_b          = (r_state == ST_A1);
    w_pixel_read = 1'b0;
    w_pixel_addr = '0;
    if ((r_state == ST_A0) || (r_state == ST_A1)) begin
      w_pixel_read = 1'b1;
      if (r_gfx) begin
        w_pixel_addr = {BASE_ADDR[18:14], r_ra0, r_ma[11:0], w_b};
      end else begin
        w_pixel_addr = {BASE_ADDR[18:14], r_ma, w_b};
      end
    end
  end

  assign bus.pixel_read  = w_pixel_read;
  assign bus.pixel_addr  = w_pixel_addr;
  assign bus.byte0       = r_byte0;
  assign bus.byte1       = r_byte1;
  assign bus.blank       = r_blank;
  assign bus.fetch_valid = r_fetch_valid;
  assign bus.overrun     = r_overrun;

endmodule

// File: tb/tb_cga_pixel_fetch.sv
// tb/tb_cga_pixel_fetch.sv - self-checking bench for cga_pixel_fetch against a slot-level reference model
module tb_cga_pixel_fetch;

`ifdef CGA_SNOW_EN
  localparam bit SNOW = 1'b1;
`else
  localparam bit SNOW = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_l;
  always #5 clk = ~clk;

  cga_pixel_fetch_if bus_if();

  cga_pixel_fetch dut (
    .clk     (clk),
    .reset_l (reset_l),
    .bus     (bus_if)
  );

  logic [7:0] mem [16384];
  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] sh0;
  logic [7:0] sh1;
  logic ov_m;

  // Registered VRAM read port: data for the address seen at this edge, 8'hFF when pre-empted
  always @(posedge clk) begin
    if (!bus_if.pixel_read) bus_if.pixel_data <= 8'h00;
    else if (bus_if.vram_busy) bus_if.pixel_data <= 8'hFF;
    else bus_if.pixel_data <= mem[bus_if.pixel_addr[13:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_byte(input int idx, input logic [18:0] a, input logic busy);
    logic [7:0] v;
    if (!busy) begin
      v = mem[a[13:0]];
      if (idx == 0) sh0 = v; else sh1 = v;
    end else if (SNOW) begin
      v = 8'hFF;
    end else begin
      v = (idx == 0) ? sh0 : sh1;
    end
    return v;
  endfunction

  // One character slot; extra != 0 pulses a second char_clk in that cycle after the first
  task automatic run_slot(input logic [13:0] ma, input logic [4:0] ra, input logic gfx,
                          input logic de, input logic bz0, input logic bz1, input int extra);
    int off;
    int ncyc;
    logic [18:0] a0, a1, aexp;
    logic [7:0] e0, e1;
    logic eblank;
    off = gfx ? (int'(ra) % 2) * 8192 + (int'(ma) % 4096) * 2 : (int'(ma) % 8192) * 2;
    a0 = 19'(32'h18000 + off);
    a1 = a0 + 19'd1;
    if (de) begin
      e0 = model_byte(0, a0, bz0);
      e1 = model_byte(1, a1, bz1);
      eblank = 1'b0;
    end else begin
      e0 = 8'h00;
      e1 = 8'h00;
      eblank = 1'b1;
    end
    @(negedge clk);
    bus_if.char_clk       = 1'b1;
    bus_if.crtc_addr      = ma;
    bus_if.row_addr       = ra;
    bus_if.graphics_mode  = gfx;
    bus_if.display_enable = de;
    ncyc = de ? 7 : 4;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      bus_if.char_clk = (k == extra);
      if (k == 1) begin
        bus_if.crtc_addr      = 14'($urandom);
        bus_if.row_addr       = 5'($urandom);
        bus_if.graphics_mode  = 1'($urandom);
        bus_if.display_enable = 1'($urandom);
      end
      bus_if.vram_busy = de && ((k == 1 && bz0) || (k == 2 && bz1));
      check("overrun", 32'(bus_if.overrun), 32'(ov_m));
      if (k == extra) ov_m = 1'b1;
      aexp = (de && k == 1) ? a0 : (de && k == 2) ? a1 : 19'd0;
      check("pixel_read", 32'(bus_if.pixel_read), 32'(de && k <= 2));
      check("pixel_addr", 32'(bus_if.pixel_addr), 32'(aexp));
      check("fetch_valid", 32'(bus_if.fetch_valid), 32'(de ? (k == 4) : (k == 2)));
      if ((de && k >= 4) || (!de && k >= 2)) begin
        check("byte0", 32'(bus_if.byte0), 32'(e0));
        check("byte1", 32'(bus_if.byte1), 32'(e1));
        check("blank", 32'(bus_if.blank), 32'(eblank));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
    reset_l               = 1'b0;
    bus_if.char_clk       = 1'b0;
    bus_if.display_enable = 1'b0;
    bus_if.graphics_mode  = 1'b0;
    bus_if.crtc_addr      = '0;
    bus_if.row_addr       = '0;
    bus_if.vram_busy      = 1'b0;
    sh0 = 8'h00;
    sh1 = 8'h00;
    ov_m = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pixel_addr", 32'(bus_if.pixel_addr), 32'd0);
    check("rst_pixel_read", 32'(bus_if.pixel_read), 32'd0);
    check("rst_byte0", 32'(bus_if.byte0), 32'd0);
    check("rst_byte1", 32'(bus_if.byte1), 32'd0);
    check("rst_fetch_valid", 32'(bus_if.fetch_valid), 32'd0);
    check("rst_blank", 32'(bus_if.blank), 32'd0);
    check("rst_overrun", 32'(bus_if.overrun), 32'd0);
    reset_l = 1'b1;

    // Text fetch
    mem[14'h0246] = 8'h41;
    mem[14'h0247] = 8'h1F;
    run_slot(14'h0123, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    check("text_byte0", 32'(bus_if.byte0), 32'h41);
    check("text_byte1", 32'(bus_if.byte1), 32'h1F);

    // Graphics odd bank, then blank slot
    run_slot(14'h0010, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    run_slot(14'($urandom), 5'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Collision on byte 0 after a clean 41
    run_slot(14'h0123, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    run_slot(14'h0123, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    check("collision_byte0", 32'(bus_if.byte0), SNOW ? 32'hFF : 32'h41);

    // Randomized slots, MA upper bits exercised for wrap
    for (int n = 0; n < 24; n++) begin
      run_slot(14'($urandom), 5'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 0);
    end

    // Overrun: second char_clk two cycles into a fetch
    run_slot(14'h0321, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2);
    run_slot(14'($urandom), 5'($urandom), 1'b1, 1'b1, 1'b0, 1'b0, 0);
    check("overrun_sticky", 32'(bus_if.overrun), 32'd1);

    // Reset during A1
    @(negedge clk);
    bus_if.char_clk       = 1'b1;
    bus_if.crtc_addr      = 14'h0055;
    bus_if.display_enable = 1'b1;
    bus_if.graphics_mode  = 1'b0;
    @(negedge clk);
    bus_if.char_clk = 1'b0;
    @(negedge clk);
    check("midrst_in_a1", 32'(bus_if.pixel_addr), 32'h180AB);
    reset_l = 1'b0;
    #1;
    check("midrst_pixel_read", 32'(bus_if.pixel_read), 32'd0);
    check("midrst_pixel_addr", 32'(bus_if.pixel_addr), 32'd0);
    check("midrst_byte0", 32'(bus_if.byte0), 32'd0);
    check("midrst_byte1", 32'(bus_if.byte1), 32'd0);
    check("midrst_blank", 32'(bus_if.blank), 32'd0);
    check("midrst_overrun", 32'(bus_if.overrun), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("midrst_fetch_valid", 32'(bus_if.fetch_valid), 32'd0);
    end
    reset_l = 1'b1;
    sh0 = 8'h00;
    sh1 = 8'h00;
    ov_m = 1'b0;

    // Normal fetch after reset, then char_clk landing in DONE
    run_slot(14'h0123, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    run_slot(14'h1ABC, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 4);
    check("overrun_done_edge", 32'(bus_if.overrun), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
